serial_subtractor: RTL

- Bit-serial N-bit subtractor that computes A − B, LSB first, using one full-adder cell: the B bit is inverted and the carry-in is seeded to 1.
- It is the inverse-direction companion of the ripple-carry adder datapath. It is an area-minimal alternative that trades latency for a single adder cell.
- Used by the project datapath wherever a multi-cycle difference is acceptable.
- Start/busy/done handshake. Registered results.

---
 rtl/serial_subtractor.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor
// ----------------------------------------------------------------------------
// Bit-serial WIDTH-bit subtractor computing a - b, LSB first, with a single
// full-adder cell. The subtrahend is inverted on load and the carry is seeded
// to 1. A subtraction takes WIDTH RUN cycles, then one DONE cycle.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request, sampled only in IDLE
//   a        in   minuend, captured on the accepted start edge
//   b        in   subtrahend, captured on the accepted start edge
//   busy     out  high while the operation runs (RUN)
//   done     out  one-cycle pulse when the results update (DONE)
//   diff     out  a - b modulo 2^WIDTH (registered, held until next completion)
//   borrow   out  1 iff a < b, unsigned
//   overflow out  two's-complement overflow of a - b
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic [CW-1:0]    count;
    logic             a_msb;
    logic             b_msb;

    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] result_nxt;

    // The single full-adder cell, plus the shift-in of its sum bit. The final
    // result is taken from result_nxt so the outputs load on the same edge as
    // the last bit is produced.
    always_comb begin
        sum_bit    = ra[0] ^ rb[0] ^ carry;
        carry_nxt  = (ra[0] & rb[0]) | (carry & (ra[0] ^ rb[0]));
        result_nxt = {sum_bit, result[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ra       <= '0;
            rb       <= '0;
            result   <= '0;
            carry    <= 1'b0;
            count    <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= ~b;
                        carry <= 1'b1;
                        count <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry  <= carry_nxt;
                    result <= result_nxt;
                    ra     <= ra >> 1;
                    rb     <= rb >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST_COUNT) begin
                        // A final carry of 1 means no borrow out of a + ~b + 1.
                        diff     <= result_nxt;
                        borrow   <= ~carry_nxt;
                        overflow <= (a_msb != b_msb) && (result_nxt[WIDTH-1] != a_msb);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
